snn_loader_ctrl: RTL and testbench

SNN_LOADER_CTRL -- requirements
Module: snn_loader_ctrl

---
 rtl/snn_pkg.sv | 21 ++
 rtl/snn_loader_ctrl.sv | 124 ++++++++++++
 tb/tb_snn_loader_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN image loader / result sender.
//   IMG_PIXELS : pixels in one 28x28 binary image
//   IMG_BYTES  : packed bytes per image (8 pixels per byte)
//   ASCII_ZERO : ASCII code of '0'; its upper nibble prefixes the digit
//   state_t    : controller state encoding
package snn_pkg;

  localparam int unsigned IMG_PIXELS = 784;
  localparam int unsigned IMG_BYTES  = 98;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_UNPACK  = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_TX      = 3'd4,
    S_TX_WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/snn_loader_ctrl.sv
// snn_loader_ctrl
// Receives a packed binary image byte by byte, unpacks it one pixel per
// cycle into the 1 x 784 input-image RAM, starts the SNN core, waits for
// its classification and sends the digit back as one ASCII byte.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_rdy      pulse: rx_data holds a received image byte
//   rx_data     8 pixels, LSB = lowest pixel index
//   tx_done     pulse: transmitter finished the last byte
//   tx_start    pulse: transmit tx_data
//   tx_data     ASCII result byte, always {4'h3, digit}
//   core_start  pulse: begin inference
//   core_done   pulse: inference finished, core_digit valid
//   core_digit  classification result
//   core_addr   image read address from the core
//   ram_addr    image RAM address (pix_cnt while loading, else core_addr)
//   ram_d       pixel write data
//   ram_we      pixel write enable (UNPACK only)
//   digit       last classified digit, held
//   busy        high in every state except LOAD
module snn_loader_ctrl
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  input  logic [9:0] core_addr,
  output logic [9:0] ram_addr,
  output logic       ram_d,
  output logic       ram_we,
  output logic [3:0] digit,
  output logic       busy
);

  localparam logic [9:0] LAST_PIX = 10'(IMG_PIXELS - 1);

  state_t     state;
  logic [9:0] pix_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      pix_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      digit      <= '0;
      tx_start   <= 1'b0;
      core_start <= 1'b0;
    end else begin
      // Pulses are asserted on the transition into START / TX and last
      // exactly the one cycle spent in those states.
      tx_start   <= 1'b0;
      core_start <= 1'b0;
      case (state)
        S_LOAD: begin
          if (rx_rdy) begin
            shift   <= rx_data;
            bit_cnt <= '0;
            state   <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          shift   <= {1'b0, shift[7:1]};
          pix_cnt <= pix_cnt + 10'd1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            // Decide on the pixel index of this (8th) write, before the
            // increment lands.
            if (pix_cnt == LAST_PIX) begin
              state      <= S_START;
              core_start <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end

        S_START: state <= S_WAIT;

        S_WAIT: begin
          if (core_done) begin
            digit    <= core_digit;
            tx_start <= 1'b1;
            state    <= S_TX;
          end
        end

        S_TX: state <= S_TX_WAIT;

        S_TX_WAIT: begin
          // pix_cnt stays at 784 through inference; it is rewound only
          // once the result has left, ready for the next image.
          if (tx_done) begin
            pix_cnt <= '0;
            state   <= S_LOAD;
          end
        end

        default: state <= S_LOAD;
      endcase
    end
  end

  // The RAM port belongs to the loader while filling and to the core
  // otherwise.
  assign ram_addr = (state == S_LOAD || state == S_UNPACK) ? pix_cnt : core_addr;
  assign ram_we   = (state == S_UNPACK);
  assign ram_d    = shift[0];
  assign tx_data  = {ASCII_ZERO[7:4], digit};
  assign busy     = (state != S_LOAD);

endmodule

// File: tb/tb_snn_loader_ctrl.sv
// Randomized self-checking bench for snn_loader_ctrl. A reference image
// array predicts every pixel; a negedge monitor records RAM writes and
// output pulses for comparison against it.
module tb_snn_loader_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic [9:0] core_addr;
  logic [9:0] ram_addr;
  logic       ram_d;
  logic       ram_we;
  logic [3:0] digit;
  logic       busy;

  snn_loader_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .tx_done    (tx_done),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .core_addr  (core_addr),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .digit      (digit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference image and observation log
  logic [7:0]   img [98];
  logic [783:0] mem;
  int cyc = 0;
  int wr_cnt, wr_order_err, cs_cnt, ts_cnt;
  int last_wr_cyc, cs_cyc, ts_cyc, cd_cyc;
  logic [7:0] ts_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_we) begin
      if (ram_addr < 10'd784) mem[ram_addr] = ram_d;
      if (int'(ram_addr) != wr_cnt) wr_order_err++;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (core_start) begin cs_cnt++; cs_cyc = cyc; end
    if (tx_start) begin ts_cnt++; ts_cyc = cyc; ts_data = tx_data; end
    if (core_done) cd_cyc = cyc;
  end

  task automatic clear_log();
    mem = '0; wr_cnt = 0; wr_order_err = 0; cs_cnt = 0; ts_cnt = 0;
    last_wr_cyc = 0; cs_cyc = 0; ts_cyc = 0; cd_cyc = 0; ts_data = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stray);
    wait_idle("send");
    rx_data = b; rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    if (stray) begin
      rx_data = ~b; rx_rdy = 1'b1;   // arrives mid-UNPACK, must be dropped
      tick();
      rx_rdy = 1'b0;
    end
    rx_data = $urandom;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data = b; rx_rdy = 1'b1; tick(); rx_rdy = 1'b0;
  endtask

  task automatic run_image(input string tag, input logic [3:0] dg, input bit fill_a5,
                           input bit stray, input logic [9:0] caddr);
    int errs, n;
    logic [3:0] junk;
    clear_log();
    for (int i = 0; i < 98; i++) img[i] = fill_a5 ? 8'hA5 : 8'($urandom);
    for (int i = 0; i < 98; i++) begin
      if (i == 97) check({tag, "_no_early_core_start"}, 32'(cs_cnt), 32'd0);
      send_byte(img[i], stray && ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end
    n = 0;
    while (cs_cnt == 0 && n < 50) begin tick(); n++; end
    check({tag, "_core_start_cnt"}, 32'(cs_cnt), 32'd1);
    check({tag, "_write_cnt"}, 32'(wr_cnt), 32'd784);
    errs = 0;
    for (int p = 0; p < 784; p++)
      if (mem[p] !== ((img[p / 8] >> (p % 8)) & 8'd1) != 8'd0) errs++;
    check({tag, "_pixel_errs"}, 32'(errs), 32'd0);
    check({tag, "_write_order"}, 32'(wr_order_err), 32'd0);
    check({tag, "_core_start_lat"}, 32'(cs_cyc - last_wr_cyc), 32'd1);

    // WAIT: RAM port follows the core, loader ignores rx_rdy
    core_addr = caddr; #1;
    check({tag, "_wait_ram_addr"}, 32'(ram_addr), 32'(caddr));
    check({tag, "_wait_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_wait_busy"}, 32'(busy), 32'd1);
    pulse_rx(8'hFF);
    tick();
    check({tag, "_wait_rx_dropped"}, 32'(wr_cnt), 32'd784);

    core_digit = dg; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    do junk = 4'($urandom); while (junk == dg);
    core_digit = junk;
    n = 0;
    while (ts_cnt == 0 && n < 20) begin tick(); n++; end
    check({tag, "_tx_start_cnt"}, 32'(ts_cnt), 32'd1);
    check({tag, "_tx_data"}, 32'(ts_data), 32'(8'h30 + 8'(dg)));
    check({tag, "_tx_start_lat"}, 32'(ts_cyc - cd_cyc), 32'd1);
    check({tag, "_digit"}, 32'(digit), 32'(dg));

    // TX_WAIT: stray rx_rdy and core_done have no effect
    pulse_rx(8'h0F);
    core_done = 1'b1; tick(); core_done = 1'b0;
    tick();
    check({tag, "_txw_rx_dropped"}, 32'(wr_cnt), 32'd784);
    check({tag, "_txw_digit_held"}, 32'(digit), 32'(dg));
    check({tag, "_txw_busy"}, 32'(busy), 32'd1);

    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check({tag, "_idle_after_tx"}, 32'(busy), 32'd0);
    check({tag, "_ram_addr_rewound"}, 32'(ram_addr), 32'd0);

    // LOAD: stray core_done must not touch digit
    core_done = 1'b1; tick(); core_done = 1'b0;
    check({tag, "_load_digit_held"}, 32'(digit), 32'(dg));
    check({tag, "_load_tx_data"}, 32'(tx_data), 32'(8'h30 + 8'(dg)));
    check({tag, "_single_tx_start"}, 32'(ts_cnt), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    core_done = 1'b0; core_digit = 4'h0; core_addr = 10'h000;
    clear_log();
    do_reset();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h30);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);

    // Uniform 0xA5 image, digit 7, core address 0x155
    run_image("a5", 4'd7, 1'b1, 1'b0, 10'h155);

    // Back-to-back random images with stray rx_rdy during UNPACK
    run_image("img3", 4'd3, 1'b0, 1'b1, 10'($urandom_range(0, 783)));
    run_image("img9", 4'd9, 1'b0, 1'b1, 10'($urandom_range(0, 783)));

    // Reset after byte 50 discards the partial image
    clear_log();
    for (int i = 0; i < 50; i++) send_byte(8'($urandom), 1'b0);
    rst_n = 1'b0; tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ram_we", 32'(ram_we), 32'd0);
    check("midrst_digit", 32'(digit), 32'd0);
    rst_n = 1'b1; tick();
    check("midrst_ram_addr", 32'(ram_addr), 32'd0);
    run_image("after_rst", 4'd12, 1'b0, 1'b0, 10'($urandom_range(0, 1023)));

    // Digits above 9 pass through unchanged
    run_image("dig15", 4'd15, 1'b0, 1'b1, 10'($urandom_range(0, 1023)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
